// File: rtl/fm7_sdram_pkg.sv
// Shared SDRAM definitions for the FM-7 memory path: address width,
// requester indices and the read-arbiter state encoding.
package fm7_sdram_pkg;

    localparam int          SDRAM_ADDR_W = 25;
    localparam logic [24:0] TAPE_BASE    = 25'h62;

    localparam int REQ_TAPE = 0;
    localparam int REQ_FDD  = 1;
    localparam int REQ_ROM  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    // Pointer width for n requesters; a single requester still needs one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set-bit search: returns the first asserted request at or
// after rr, wrapping from NREQ-1 back to 0.
module rr_pick
    import fm7_sdram_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr,
    output logic [PW-1:0]   grant,
    output logic            any
);

    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0] w_idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        w_idx = rr;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[w_idx]) begin
                grant = w_idx;
                any   = 1'b1;
            end
            w_idx = (w_idx == LAST) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sdram_rd_arb.sv
// Round-robin arbiter sharing the SDRAM read channel between level-handshake
// requesters, with a per-read timeout so a stalled controller cannot hang a client.
module sdram_rd_arb
    import fm7_sdram_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = SDRAM_ADDR_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                   CLKSYS,
    input  logic                   RESET,
    input  logic [NREQ-1:0]        req_rd,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [15:0]            req_data,
    output logic [NREQ-1:0]        req_stb,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [15:0]            mem_dout,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PW = ptr_w(NREQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    arb_state_t        r_state, w_state_nxt;
    logic [PW-1:0]     r_rr, w_rr_nxt;
    logic [PW-1:0]     r_grant, w_grant_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_mem_rd, w_mem_rd_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [NREQ-1:0]   r_stb, w_stb_nxt;
    logic [15:0]       r_data, w_data_nxt;
    logic              r_tout, w_tout_nxt;

    logic [PW-1:0]     w_pick;
    logic              w_any;
    logic [NREQ-1:0]   w_g_oh;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req_rd),
        .rr    (r_rr),
        .grant (w_pick),
        .any   (w_any)
    );

    always_ff @(posedge CLKSYS or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_rr       <= '0;
            r_grant    <= '0;
            r_cnt      <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_stb      <= '0;
            r_data     <= '0;
            r_tout     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_grant    <= w_grant_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_stb      <= w_stb_nxt;
            r_data     <= w_data_nxt;
            r_tout     <= w_tout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr;
        w_grant_nxt    = r_grant;
        w_cnt_nxt      = r_cnt;
        w_mem_rd_nxt   = r_mem_rd;
        w_mem_addr_nxt = r_mem_addr;
        w_stb_nxt      = r_stb;
        w_data_nxt     = r_data;
        w_tout_nxt     = 1'b0;
        w_g_oh         = '0;
        w_g_oh[r_grant] = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt    = w_pick;
                    w_mem_addr_nxt = req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                    w_mem_rd_nxt   = 1'b1;
                    w_cnt_nxt      = CW'(TIMEOUT);
                    w_rr_nxt       = (w_pick == LAST) ? '0 : w_pick + 1'b1;
                    w_state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack in the same cycle the counter expires takes priority.
                if (mem_ack) begin
                    w_mem_rd_nxt = 1'b0;
                    if (req_rd[r_grant]) begin
                        w_data_nxt  = mem_dout;
                        w_stb_nxt   = w_g_oh;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_cnt <= CW'(1)) begin
                    w_mem_rd_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_data_nxt   = 16'hFFFF;
                    w_stb_nxt    = req_rd[r_grant] ? w_g_oh : '0;
                    w_tout_nxt   = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_HOLD, ST_DRAIN: begin
                if (!req_rd[r_grant]) begin
                    w_stb_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign mem_rd      = r_mem_rd;
    assign mem_addr    = r_mem_addr;
    assign req_stb     = r_stb;
    assign req_data    = r_data;
    assign timeout_err = r_tout;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdram_rd_arb.sv
// Scoreboard bench for sdram_rd_arb: stimulus queues expected grant addresses
// and strobe responses, a negedge monitor pops and compares them as they appear.
module tb_sdram_rd_arb;

    logic        CLKSYS = 1'b0;
    logic        RESET  = 1'b1;
    logic [2:0]  req_rd = '0;
    logic [74:0] req_addr = '0;
    logic [15:0] req_data;
    logic [2:0]  req_stb;
    logic        mem_rd;
    logic [24:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_dout = '0;
    logic        busy;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    logic [24:0] q_addr[$];
    logic [18:0] q_rsp[$];
    logic        m_prev_rd  = 1'b0;
    logic [2:0]  m_prev_stb = '0;

    sdram_rd_arb #(
        .NREQ    (3),
        .ADDR_W  (25),
        .TIMEOUT (15)
    ) u_dut (
        .CLKSYS      (CLKSYS),
        .RESET       (RESET),
        .req_rd      (req_rd),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_stb     (req_stb),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_dout    (mem_dout),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 CLKSYS = ~CLKSYS;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: new grant (mem_rd rising) and new response (req_stb leaving zero).
    always @(negedge CLKSYS) begin
        logic [24:0] ea;
        logic [18:0] er;
        if (mem_rd && !m_prev_rd) begin
            if (q_addr.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL grant_unexpected: mem_addr %h with none expected", mem_addr);
            end else begin
                ea = q_addr.pop_front();
                check("grant_addr", {7'b0, mem_addr}, {7'b0, ea});
            end
        end
        if (req_stb != 3'b000 && m_prev_stb == 3'b000) begin
            if (q_rsp.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL strobe_unexpected: stb %b data %h with none expected", req_stb, req_data);
            end else begin
                er = q_rsp.pop_front();
                check("rsp_stb",  {29'b0, req_stb}, {29'b0, er[18:16]});
                check("rsp_data", {16'b0, req_data}, {16'b0, er[15:0]});
            end
        end
        m_prev_rd  = mem_rd;
        m_prev_stb = req_stb;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLKSYS);
    endtask

    task automatic wait_rd();
        int n = 0;
        while (!mem_rd && n < 50) begin
            tick(1);
            n++;
        end
        if (!mem_rd) check("mem_rd_wait", {31'b0, mem_rd}, 32'd1);
    endtask

    task automatic pulse_ack(input logic [15:0] d);
        mem_ack  = 1'b1;
        mem_dout = d;
        tick(1);
        mem_ack  = 1'b0;
    endtask

    task automatic release_req(input int g);
        req_rd[g] = 1'b0;
        tick(1);
        check("release_stb",  {29'b0, req_stb}, 32'd0);
        check("release_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic set_addr(input int g, input logic [24:0] a);
        req_addr[g*25 +: 25] = a;
    endtask

    initial begin
        int n_hi;
        int stable;
        logic [2:0] exp_g[4];
        exp_g = '{3'd0, 3'd1, 3'd2, 3'd0};

        // Reset values
        tick(2);
        check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("rst_mem_addr", {7'b0, mem_addr}, 32'd0);
        check("rst_stb", {29'b0, req_stb}, 32'd0);
        check("rst_data", {16'b0, req_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_tout", {31'b0, timeout_err}, 32'd0);
        RESET = 1'b0;

        // Single requester: tape, ack after 5 cycles
        set_addr(0, 25'h62);
        q_addr.push_back(25'h62);
        q_rsp.push_back({3'b001, 16'h8012});
        req_rd = 3'b001;
        wait_rd();
        tick(4);
        pulse_ack(16'h8012);
        check("single_mem_rd_low", {31'b0, mem_rd}, 32'd0);
        tick(2);
        check("single_hold_stb", {29'b0, req_stb}, 32'd1);
        check("single_hold_data", {16'b0, req_data}, 32'h8012);
        release_req(0);

        // Contention after reset: grants 0,1,2,0
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        set_addr(0, 25'h0000100);
        set_addr(1, 25'h0000200);
        set_addr(2, 25'h1000300);
        for (int i = 0; i < 4; i++) begin
            q_addr.push_back(req_addr[exp_g[i]*25 +: 25]);
            q_rsp.push_back({3'b001 << exp_g[i], 16'h1110 + 16'(i)});
        end
        req_rd = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_rd();
            tick(1);
            pulse_ack(16'h1110 + 16'(i));
            release_req(int'(exp_g[i]));
            req_rd[exp_g[i]] = (i < 3);
        end
        req_rd = 3'b000;

        // Slow client: 40 cycles of hold with a stray ack in the middle
        set_addr(0, 25'h62);
        q_addr.push_back(25'h62);
        q_rsp.push_back({3'b001, 16'hA5C3});
        req_rd = 3'b001;
        wait_rd();
        tick(2);
        pulse_ack(16'hA5C3);
        stable = 0;
        for (int j = 0; j < 40; j++) begin
            if (req_stb == 3'b001 && req_data == 16'hA5C3 && !mem_rd && busy) stable++;
            mem_ack  = (j == 20);
            mem_dout = 16'h0BAD;
            tick(1);
        end
        mem_ack = 1'b0;
        check("slow_stable_cycles", stable, 32'd40);
        release_req(0);

        // Timeout on floppy: no ack for 15 WAIT cycles
        set_addr(1, 25'h001ABCD);
        q_addr.push_back(25'h001ABCD);
        q_rsp.push_back({3'b010, 16'hFFFF});
        req_rd = 3'b010;
        wait_rd();
        n_hi = 0;
        while (mem_rd && n_hi < 40) begin
            n_hi++;
            tick(1);
        end
        check("tout_wait_cycles", n_hi, 32'd15);
        check("tout_err_pulse", {31'b0, timeout_err}, 32'd1);
        tick(1);
        check("tout_err_clear", {31'b0, timeout_err}, 32'd0);
        pulse_ack(16'h1234);
        check("drain_data", {16'b0, req_data}, 32'hFFFF);
        check("drain_stb", {29'b0, req_stb}, 32'd2);
        check("drain_busy", {31'b0, busy}, 32'd1);
        release_req(1);
        pulse_ack(16'h5678);
        check("idle_late_ack_rd", {31'b0, mem_rd}, 32'd0);
        check("idle_late_ack_busy", {31'b0, busy}, 32'd0);

        // Abort: floppy drops during WAIT; ROM then wins over tape via rr
        set_addr(1, 25'h0005555);
        q_addr.push_back(25'h0005555);
        q_addr.push_back(25'h1FFFFFF);
        q_rsp.push_back({3'b100, 16'h2222});
        req_rd = 3'b010;
        wait_rd();
        set_addr(0, 25'h62);
        set_addr(2, 25'h1FFFFFF);
        req_rd = 3'b101;
        tick(1);
        pulse_ack(16'hDEAD);
        check("abort_stb", {29'b0, req_stb}, 32'd0);
        check("abort_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("abort_idle", {31'b0, busy}, 32'd0);
        wait_rd();
        tick(1);
        pulse_ack(16'h2222);
        release_req(2);

        // Reset mid-WAIT on the tape transaction
        q_addr.push_back(25'h62);
        wait_rd();
        tick(2);
        #2 RESET = 1'b1;
        #1;
        check("mid_rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("mid_rst_addr", {7'b0, mem_addr}, 32'd0);
        check("mid_rst_stb", {29'b0, req_stb}, 32'd0);
        check("mid_rst_data", {16'b0, req_data}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_tout", {31'b0, timeout_err}, 32'd0);
        req_rd = 3'b000;
        @(negedge CLKSYS);
        RESET = 1'b0;
        pulse_ack(16'h7777);
        check("post_rst_ack_busy", {31'b0, busy}, 32'd0);
        check("post_rst_ack_rd", {31'b0, mem_rd}, 32'd0);
        tick(1);

        // rr cleared by reset: tape wins over ROM
        set_addr(0, 25'h0000ABC);
        set_addr(2, 25'h1234567);
        q_addr.push_back(25'h0000ABC);
        q_rsp.push_back({3'b001, 16'h0F0F});
        req_rd = 3'b101;
        wait_rd();
        tick(1);
        pulse_ack(16'h0F0F);
        req_rd = 3'b000;
        tick(1);
        check("final_stb", {29'b0, req_stb}, 32'd0);
        tick(3);

        check("addr_queue_empty", q_addr.size(), 32'd0);
        check("rsp_queue_empty", q_rsp.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_rd_arb.md
# sdram_rd_arb

Round-robin read arbiter that shares the single SDRAM read port among `NREQ` independent requesters: the T77 tape decoder, the floppy image reader and the ROM/BIOS shadow loader. Each requester uses a level-held 4-phase handshake, so slow or clock-enable-gated clients such as the 9 µs tape engine cannot miss a response. The block sits between the requesters and the SDRAM controller's read channel. It also bounds each memory transaction with a timeout so that a stalled controller cannot hang the tape or disk path.

## Interface
Parameters:
- `NREQ`, 3, number of requesters. Index 0 = tape, 1 = floppy, 2 = ROM loader.
- `ADDR_W`, 25, SDRAM word-address width.
- `TIMEOUT`, 1023, maximum cycles to wait for `mem_ack` before an aborted read returns.

Ports:
- `CLKSYS` in 1: system clock. Everything is on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `req_rd` in `NREQ`: per-requester read request, held high until its `req_stb` is seen.
- `req_addr` in `NREQ*ADDR_W`: packed addresses. Slice i = `[i*ADDR_W +: ADDR_W]`. Must be stable while `req_rd[i]` is high.
- `req_data` out 16: shared read data. Valid while any `req_stb` bit is high.
- `req_stb` out `NREQ`: per-requester completion. Level, one-hot or zero.
- `mem_rd` out 1: read request to the SDRAM controller. Level, held until `mem_ack`.
- `mem_addr` out `ADDR_W`: address to the SDRAM controller.
- `mem_ack` in 1: one-cycle pulse, `mem_dout` valid in the same cycle.
- `mem_dout` in 16: SDRAM read data.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: one-cycle pulse when a read times out.

## Operation
- States: IDLE, WAIT, HOLD, DRAIN.
- Reset (async) puts the FSM in IDLE with these register values:
  - `mem_rd`=0, `mem_addr`=0, `req_stb`=0, `req_data`=0, `busy`=0, `timeout_err`=0.
  - Round-robin pointer `rr`=0 and `grant`=0.
- IDLE, on any `req_rd` bit high:
  - Grant g = first set bit searching circularly from `rr`.
  - Latch the address slice g into `mem_addr`, set `mem_rd`=1, load the timeout counter with `TIMEOUT`, set `rr`=(g+1) mod `NREQ`, and go to WAIT.
- WAIT:
  - On `mem_ack`: `mem_rd`=0.
    - If `req_rd[g]` is still high: `req_data`=`mem_dout`, `req_stb[g]`=1, go to HOLD.
    - If `req_rd[g]` has dropped (abort): data discarded, no strobe, go to IDLE.
  - Otherwise the counter decrements. When it reaches 0: `mem_rd`=0, `req_data`=16'hFFFF, `req_stb[g]`=1 (`req_stb` is not raised if `req_rd[g]` has dropped), `timeout_err` pulses, go to DRAIN.
- HOLD: `req_data` and `req_stb[g]` stay fixed until `req_rd[g]` is sampled low. Then `req_stb`=0 and go to IDLE.
- DRAIN: behaves like HOLD and also absorbs one late `mem_ack` (ignored). Leave for IDLE when `req_rd[g]` is low. Any late ack after that is ignored in IDLE.
- `mem_ack` in IDLE or HOLD is ignored.
- Width rules:
  - `rr` and `grant` are `$clog2(NREQ)` bits wide. Wrap from `NREQ`-1 to 0 explicitly.
  - The counter is `$clog2(TIMEOUT+1)` bits wide.

## Timing
- Grant latency: `req_rd` high at edge N in IDLE gives `mem_rd`/`mem_addr` valid after edge N.
- Response: `mem_ack` sampled at edge M gives `req_stb[g]` and `req_data` valid after edge M, and `mem_rd` low after edge M.
- Release: `req_rd[g]` low sampled at edge K gives `req_stb` low after K. The earliest next grant is at edge K+1, so at least one IDLE cycle separates transactions.
- Minimum transaction: 3 cycles plus the SDRAM latency.
- Fairness: a continuously asserting requester waits at most `NREQ`-1 transactions.
- Simultaneous events:
  - `mem_ack` and a counter reaching 0 in the same cycle: the ack wins.
  - New requests during WAIT, HOLD or DRAIN are only considered on return to IDLE.

## Structure
- Shared package `fm7_sdram_pkg`: `SDRAM_ADDR_W`=25, `TAPE_BASE`=25'h62, requester index constants `REQ_TAPE`/`REQ_FDD`/`REQ_ROM`, and the state enum `arb_state_t`.
- One sub-module, `rr_pick`: combinational circular first-set-bit search. Inputs `req` and `rr`. Outputs `grant` and `any`.

## Test plan
- Single requester: tape `req_rd[0]`=1, addr 25'h62. Controller acks after 5 cycles with 16'h8012. Expect `mem_addr`=25'h62, `req_data`=16'h8012, `req_stb`=3'b001 held until `req_rd[0]` drops, then one IDLE cycle.
- Contention: all three requesters assert at once after reset. Expect grants in order 0,1,2,0 with `rr` wrap, and each `req_stb` one-hot.
- Slow client: `req_rd[0]` is released 40 cycles after the strobe. Expect `req_stb[0]` and `req_data` stable for all 40 cycles, with no second `mem_rd`.
- Timeout: `TIMEOUT`=15 and no ack. Expect `mem_rd` low after 15 WAIT cycles, `req_data`=16'hFFFF, `timeout_err` 1-cycle pulse. A late ack in DRAIN must not alter `req_data`.
- Abort: requester 1 drops `req_rd` during WAIT, then the ack arrives. Expect no `req_stb`, return to IDLE, and requester 2 granted next.
- Reset mid-WAIT: assert `RESET` asynchronously. Expect all outputs 0 immediately and `rr`=0. An ack arriving after release is ignored.
